// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Registered RV32I decode stage. An instruction/PC pair is accepted on a
// valid/ready handshake, decoded combinationally and written into the tail of
// a DEPTH-entry in-order queue. The head entry of the queue drives the control
// bundle consumed by execute. Unknown or malformed encodings produce an entry
// whose bundle is all zero with the illegal flag set. These entries still
// occupy a slot and follow the normal handshake.
//
// Optional feature:
//   DECODE_MEXT_EN  When defined, R-type funct7=0000001 (M extension) is
//                   legal and decodes to alu_ctrl={0000001,funct3}.
//                   When undefined, that encoding is flagged illegal.
//
// Parameters:
//   XLEN    datapath / immediate / PC width (>= 32)
//   DEPTH   queue depth, power of two, >= 2
//   PC_SEL  sel_a code that selects the PC as operand A (AUIPC)
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   flush                drop every queued entry (branch redirect)
//   in_valid/in_ready    input handshake; in_ready = queue not full
//   in_instr, in_pc      instruction word and its address
//   out_valid/out_ready  output handshake for the head entry
//   out_pc               PC of the head entry
//   alu_ctrl, imm,       decoded control bundle of the head entry.
//   imm_en, sel_a,       Every field is 0 when the queue is empty.
//   sel_b, sel_out,
//   jmp_type, new_jmp,
//   jalr_rs,
//   lam_control,
//   lam_new, illegal
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2,
  parameter int PC_SEL = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [9:0]      alu_ctrl,
  output logic [XLEN-1:0] imm,
  output logic            imm_en,
  output logic [5:0]      sel_a,
  output logic [4:0]      sel_b,
  output logic [5:0]      sel_out,
  output logic [2:0]      jmp_type,
  output logic            new_jmp,
  output logic [4:0]      jalr_rs,
  output logic [8:0]      lam_control,
  output logic            lam_new,
  output logic            illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef DECODE_MEXT_EN
  localparam logic MEXT_EN = 1'b1;
`else
  localparam logic MEXT_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [9:0]      alu_ctrl;
    logic [XLEN-1:0] imm;
    logic            imm_en;
    logic [5:0]      sel_a;
    logic [4:0]      sel_b;
    logic [5:0]      sel_out;
    logic [2:0]      jmp_type;
    logic            new_jmp;
    logic [4:0]      jalr_rs;
    logic [8:0]      lam_control;
    logic            lam_new;
    logic            illegal;
  } entry_t;

  // Sign-extend a 32-bit immediate to the datapath width.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // Queue state
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  entry_t dec_entry;
  logic   dec_legal;
  logic   push;
  logic   pop;

  // Combinational decode of the incoming instruction into a queue entry.
  always_comb begin
    dec_entry = '0;
    dec_legal = 1'b1;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'h00) begin
          dec_legal = 1'b1;
        end else if (funct7 == 7'h20) begin
          // Only SUB and SRA use the alternate funct7.
          dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else if (funct7 == 7'h01) begin
          dec_legal = MEXT_EN;
        end else begin
          dec_legal = 1'b0;
        end
        dec_entry.alu_ctrl = {funct7, funct3};
        dec_entry.sel_a    = {1'b0, rs1};
        dec_entry.sel_b    = rs2;
        dec_entry.sel_out  = {1'b0, rd};
      end
      OP_IMM: begin
        case (funct3)
          3'b001:  dec_legal = (funct7 == 7'h00);
          3'b101:  dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: dec_legal = 1'b1;
        endcase
        // For non-shift ops funct7 is just the top of the immediate; it is
        // carried into alu_ctrl unchanged and execute ignores it.
        dec_entry.alu_ctrl = {funct7, funct3};
        dec_entry.sel_a    = {1'b0, rs1};
        dec_entry.sel_out  = {1'b0, rd};
        dec_entry.imm      = sext32(imm_i);
        dec_entry.imm_en   = 1'b1;
      end
      OP_LOAD: begin
        dec_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        // Load writeback is owned by the LAM, so the ALU result is not written.
        dec_entry.sel_a       = {1'b0, rs1};
        dec_entry.imm         = sext32(imm_i);
        dec_entry.imm_en      = 1'b1;
        dec_entry.lam_new     = 1'b1;
        dec_entry.lam_control = {1'b0, funct3, rd};
      end
      OP_STORE: begin
        dec_legal = (funct3 < 3'b011);
        dec_entry.sel_a       = {1'b0, rs1};
        dec_entry.sel_b       = rs2;
        dec_entry.imm         = sext32(imm_s);
        dec_entry.imm_en      = 1'b1;
        dec_entry.lam_control = {1'b1, funct3, rs2};
      end
      OP_BRANCH: begin
        dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        case (funct3[2:1])
          2'b00:   dec_entry.alu_ctrl = 10'h100;
          2'b10:   dec_entry.alu_ctrl = 10'h002;
          2'b11:   dec_entry.alu_ctrl = 10'h003;
          default: dec_entry.alu_ctrl = 10'h000;
        endcase
        dec_entry.sel_a    = {1'b0, rs1};
        dec_entry.sel_b    = rs2;
        dec_entry.imm      = sext32(imm_b);
        dec_entry.new_jmp  = 1'b1;
        dec_entry.jmp_type = funct3;
      end
      OP_LUI: begin
        // Operand A is x0, so the ALU result is the U immediate itself.
        dec_entry.sel_a   = 6'd0;
        dec_entry.sel_out = {1'b0, rd};
        dec_entry.imm     = sext32(imm_u);
        dec_entry.imm_en  = 1'b1;
      end
      OP_AUIPC: begin
        dec_entry.sel_a   = 6'(PC_SEL);
        dec_entry.sel_out = {1'b0, rd};
        dec_entry.imm     = sext32(imm_u);
        dec_entry.imm_en  = 1'b1;
      end
      OP_JAL: begin
        dec_entry.sel_out  = {1'b0, rd};
        dec_entry.imm      = sext32(imm_j);
        dec_entry.new_jmp  = 1'b1;
        dec_entry.jmp_type = 3'b010;
      end
      OP_JALR: begin
        dec_legal = (funct3 == 3'b000);
        dec_entry.sel_out  = {1'b0, rd};
        dec_entry.imm      = sext32(imm_i);
        dec_entry.jalr_rs  = rs1;
        dec_entry.new_jmp  = 1'b1;
        dec_entry.jmp_type = 3'b011;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase

    // An illegal entry carries no control at all. The PC is kept so that
    // the trap logic knows where the fault happened.
    if (!dec_legal) begin
      dec_entry         = '0;
      dec_entry.illegal = 1'b1;
    end else begin
      dec_entry.illegal = 1'b0;
    end
    dec_entry.pc = in_pc;
  end

  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != CNT_W'(0));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state of queue storage, pointers and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      // The redirect invalidates everything, including a same-cycle push.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Queue registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  entry_t head;

  // Drive the bundle from the head entry; force zero when the queue is empty.
  always_comb begin
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end else begin
      head = '0;
    end
    out_pc      = head.pc;
    alu_ctrl    = head.alu_ctrl;
    imm         = head.imm;
    imm_en      = head.imm_en;
    sel_a       = head.sel_a;
    sel_b       = head.sel_b;
    sel_out     = head.sel_out;
    jmp_type    = head.jmp_type;
    new_jmp     = head.new_jmp;
    jalr_rs     = head.jalr_rs;
    lam_control = head.lam_control;
    lam_new     = head.lam_new;
    illegal     = head.illegal;
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [9:0]  alu_ctrl;
  logic [31:0] imm;
  logic        imm_en;
  logic [5:0]  sel_a;
  logic [4:0]  sel_b;
  logic [5:0]  sel_out;
  logic [2:0]  jmp_type;
  logic        new_jmp;
  logic [4:0]  jalr_rs;
  logic [8:0]  lam_control;
  logic        lam_new;
  logic        illegal;

  decode_stage #(.XLEN(32), .DEPTH(2), .PC_SEL(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_ctrl(alu_ctrl), .imm(imm), .imm_en(imm_en), .sel_a(sel_a), .sel_b(sel_b),
    .sel_out(sel_out), .jmp_type(jmp_type), .new_jmp(new_jmp), .jalr_rs(jalr_rs),
    .lam_control(lam_control), .lam_new(lam_new), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] bundle();
    return {16'h0, out_pc, alu_ctrl, imm, imm_en, sel_a, sel_b, sel_out, jmp_type,
            new_jmp, jalr_rs, lam_control, lam_new, illegal};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  alu;
    logic [31:0] imm;
    logic        ie;
    logic [5:0]  sa;
    logic [4:0]  sb;
    logic [5:0]  so;
    logic [2:0]  jt;
    logic        nj;
    logic [4:0]  jr;
    logic [8:0]  lc;
    logic        ln;
    logic        il;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] instr, input logic [9:0] alu,
                              input logic [31:0] im, input logic ie, input logic [5:0] sa,
                              input logic [4:0] sb, input logic [5:0] so, input logic [2:0] jt,
                              input logic nj, input logic [4:0] jr, input logic [8:0] lc,
                              input logic ln, input logic il);
    vec_t v;
    v.instr = instr; v.alu = alu; v.imm = im; v.ie = ie; v.sa = sa; v.sb = sb;
    v.so = so; v.jt = jt; v.nj = nj; v.jr = jr; v.lc = lc; v.ln = ln; v.il = il;
    return v;
  endfunction

  function automatic vec_t mkill(input logic [31:0] instr);
    return mk(instr, 10'h0, 32'h0, 1'b0, 6'd0, 5'd0, 6'd0, 3'd0, 1'b0, 5'd0, 9'h0, 1'b0, 1'b1);
  endfunction

  localparam int NV = 22;
  vec_t vecs [NV];

  // Push one instruction into the empty queue, hold for one cycle.
  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    //                instr          alu      imm           ie    sa     sb     so     jt    nj    jr     lc      ln    il
    vecs[0]  = mk(32'h00500093, 10'h000, 32'h00000005, 1'b1, 6'd0,  5'd0, 6'd1,  3'd0, 1'b0, 5'd0, 9'h000, 1'b0, 1'b0); // addi x1,x0,5
    vecs[1]  = mk(32'hFE208EE3, 10'h100, 32'hFFFFFFFC, 1'b0, 6'd1,  5'd2, 6'd0,  3'd0, 1'b1, 5'd0, 9'h000, 1'b0, 1'b0); // beq x1,x2,-4
`ifdef DECODE_MEXT_EN
    vecs[2]  = mk(32'h022081B3, 10'h008, 32'h00000000, 1'b0, 6'd1,  5'd2, 6'd3,  3'd0, 1'b0, 5'd0, 9'h000, 1'b0, 1'b0); // mul x3,x1,x2
`else
    vecs[2]  = mkill(32'h022081B3);                                                                                   // mul -> illegal
`endif
    vecs[3]  = mk(32'h00812283, 10'h000, 32'h00000008, 1'b1, 6'd2,  5'd0, 6'd0,  3'd0, 1'b0, 5'd0, 9'h045, 1'b1, 1'b0); // lw x5,8(x2)
    vecs[4]  = mk(32'hFE63AE23, 10'h000, 32'hFFFFFFFC, 1'b1, 6'd7,  5'd6, 6'd0,  3'd0, 1'b0, 5'd0, 9'h146, 1'b0, 1'b0); // sw x6,-4(x7)
    vecs[5]  = mk(32'h12345537, 10'h000, 32'h12345000, 1'b1, 6'd0,  5'd0, 6'd10, 3'd0, 1'b0, 5'd0, 9'h000, 1'b0, 1'b0); // lui x10
    vecs[6]  = mk(32'hABCDE597, 10'h000, 32'hABCDE000, 1'b1, 6'd32, 5'd0, 6'd11, 3'd0, 1'b0, 5'd0, 9'h000, 1'b0, 1'b0); // auipc x11
    vecs[7]  = mk(32'h008000EF, 10'h000, 32'h00000008, 1'b0, 6'd0,  5'd0, 6'd1,  3'd2, 1'b1, 5'd0, 9'h000, 1'b0, 1'b0); // jal x1,+8
    vecs[8]  = mk(32'hFF0182E7, 10'h000, 32'hFFFFFFF0, 1'b0, 6'd0,  5'd0, 6'd5,  3'd3, 1'b1, 5'd3, 9'h000, 1'b0, 1'b0); // jalr x5,-16(x3)
    vecs[9]  = mk(32'h40628233, 10'h100, 32'h00000000, 1'b0, 6'd5,  5'd6, 6'd4,  3'd0, 1'b0, 5'd0, 9'h000, 1'b0, 1'b0); // sub x4,x5,x6
    vecs[10] = mk(32'h40345393, 10'h105, 32'h00000403, 1'b1, 6'd8,  5'd0, 6'd7,  3'd0, 1'b0, 5'd0, 9'h000, 1'b0, 1'b0); // srai x7,x8,3
    vecs[11] = mk(32'h0020C863, 10'h002, 32'h00000010, 1'b0, 6'd1,  5'd2, 6'd0,  3'd4, 1'b1, 5'd0, 9'h000, 1'b0, 1'b0); // blt x1,x2,+16
    vecs[12] = mk(32'h0041F063, 10'h003, 32'h00000000, 1'b0, 6'd3,  5'd4, 6'd0,  3'd7, 1'b1, 5'd0, 9'h000, 1'b0, 1'b0); // bgeu x3,x4,0
    vecs[13] = mkill(32'h00000000); // opcode 0
    vecs[14] = mkill(32'h00002063); // branch f3=010
    vecs[15] = mkill(32'h00003003); // load f3=011
    vecs[16] = mkill(32'h00003023); // store f3=011
    vecs[17] = mkill(32'h00001067); // jalr f3=001
    vecs[18] = mkill(32'h40001033); // R f7=0x20 f3=001
    vecs[19] = mkill(32'h40001013); // slli f7!=0
    vecs[20] = mkill(32'h20005013); // srli f7=0x10
    vecs[21] = mkill(32'h00000073); // ecall

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'h0);
    chk("reset_bundle", bundle(), 128'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'h1);
    @(posedge clk); #1;

    // Table-driven decode vectors: push into empty queue, check, drain.
    for (int i = 0; i < NV; i++) begin
      push_one(vecs[i].instr, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_valid", i), 128'(out_valid), 128'h1);
      if (!vecs[i].il) begin
        chk($sformatf("v%0d_pc", i), 128'(out_pc), 128'(32'h1000 + 32'(i * 4)));
      end
      chk($sformatf("v%0d_alu", i), 128'(alu_ctrl), 128'(vecs[i].alu));
      chk($sformatf("v%0d_imm", i), 128'(imm), 128'(vecs[i].imm));
      chk($sformatf("v%0d_imm_en", i), 128'(imm_en), 128'(vecs[i].ie));
      chk($sformatf("v%0d_sel_a", i), 128'(sel_a), 128'(vecs[i].sa));
      chk($sformatf("v%0d_sel_b", i), 128'(sel_b), 128'(vecs[i].sb));
      chk($sformatf("v%0d_sel_out", i), 128'(sel_out), 128'(vecs[i].so));
      chk($sformatf("v%0d_jmp_type", i), 128'(jmp_type), 128'(vecs[i].jt));
      chk($sformatf("v%0d_new_jmp", i), 128'(new_jmp), 128'(vecs[i].nj));
      chk($sformatf("v%0d_jalr_rs", i), 128'(jalr_rs), 128'(vecs[i].jr));
      chk($sformatf("v%0d_lam_ctl", i), 128'(lam_control), 128'(vecs[i].lc));
      chk($sformatf("v%0d_lam_new", i), 128'(lam_new), 128'(vecs[i].ln));
      chk($sformatf("v%0d_illegal", i), 128'(illegal), 128'(vecs[i].il));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk($sformatf("v%0d_drained", i), 128'(out_valid), 128'h0);
    end

    // Backpressure: three pushes into a 2-deep queue with execute stalled.
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h2000;
    @(posedge clk); #1;
    chk("bp_ready_after1", 128'(in_ready), 128'h1);
    chk("bp_head1", 128'(out_pc), 128'h2000);
    in_instr = 32'h00200093; in_pc = 32'h2004;
    @(posedge clk); #1;
    chk("bp_ready_full", 128'(in_ready), 128'h0);
    chk("bp_valid_full", 128'(out_valid), 128'h1);
    in_instr = 32'h00300093; in_pc = 32'h2008;
    @(posedge clk); #1;
    chk("bp_held_ready", 128'(in_ready), 128'h0);
    chk("bp_held_head_pc", 128'(out_pc), 128'h2000);
    chk("bp_held_head_imm", 128'(imm), 128'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_pop1_pc", 128'(out_pc), 128'h2004);
    chk("bp_pop1_imm", 128'(imm), 128'h2);
    chk("bp_pop1_ready", 128'(in_ready), 128'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_pushpop_pc", 128'(out_pc), 128'h2008);
    chk("bp_pushpop_imm", 128'(imm), 128'h3);
    chk("bp_pushpop_valid", 128'(out_valid), 128'h1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_empty", 128'(out_valid), 128'h0);

    // Flush with a full queue and an offered instruction.
    in_valid = 1'b1; in_instr = 32'h00400093; in_pc = 32'h3000;
    @(posedge clk); #1;
    in_pc = 32'h3004;
    @(posedge clk); #1;
    chk("fl_full_valid", 128'(out_valid), 128'h1);
    flush = 1'b1; in_pc = 32'h3008;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_valid", 128'(out_valid), 128'h0);
    chk("fl_ready", 128'(in_ready), 128'h1);
    chk("fl_bundle", bundle(), 128'h0);
    // Flush beats a same-cycle push and pop with the queue accepting.
    in_pc = 32'h300C;
    @(posedge clk); #1;
    chk("fl_refill_pc", 128'(out_pc), 128'h300C);
    flush = 1'b1; out_ready = 1'b1; in_pc = 32'h3010;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("fl_push_dropped", 128'(out_valid), 128'h0);
    @(posedge clk); #1;
    chk("fl_push_dropped_later", 128'(out_valid), 128'h0);

    // Asynchronous reset mid-stream with two entries queued.
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h4000;
    @(posedge clk); #1;
    in_pc = 32'h4004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rs_prefill", 128'(out_valid), 128'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async_valid", 128'(out_valid), 128'h0);
    chk("rs_async_bundle", bundle(), 128'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rs_release_valid", 128'(out_valid), 128'h0);
    chk("rs_release_ready", 128'(in_ready), 128'h1);
    @(posedge clk); #1;
    push_one(32'h00700093, 32'h5000);
    chk("rs_restart_pc", 128'(out_pc), 128'h5000);
    chk("rs_restart_imm", 128'(imm), 128'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
